// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Initiator-side load/store unit for a single-port word memory bus with a
//   combinational read and a write on the rising clock edge. Accepts one RV32I
//   load/store per transaction. Loads are lane-selected and sign/zero-extended.
//   SB/SH are built as read-modify-write because the memory only writes whole
//   words. The response is a single-cycle pulse.
//
//   Build option: define LSU_RMW_EN to enable sub-word stores (SB/SH) through
//   the RMW_RD state. When it is undefined, SB/SH are rejected as illegal.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready    request handshake (ready only when idle)
//   i_req_write, i_req_funct3    store flag and RV32I funct3
//   i_req_addr, i_req_wdata      byte address, right-aligned store data
//   o_resp_valid/err/rdata       one-cycle response, error flag, load result
//   o_mem_address                word-aligned byte address to memory
//   o_mem_write_data             merged store word
//   o_mem_write_enable           write strobe, high only in WRITE
//   i_mem_read_data              combinational read data for o_mem_address
module lsu_mem_master #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [31:0] o_resp_rdata,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_write_enable,
  input  logic [31:0] i_mem_read_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RESP   = 3'd3
`ifdef LSU_RMW_EN
    ,
    ST_RMW_RD = 3'd4
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_range_err;
  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_mem_wdata_nxt;
  logic        w_resp_valid_nxt;
  logic        w_resp_err_nxt;
  logic [31:0] w_resp_rdata_nxt;
`ifdef LSU_RMW_EN
  logic [31:0] w_merge;
`endif

  assign o_req_ready        = (r_state == ST_IDLE);
  assign w_accept           = i_req_valid && (r_state == ST_IDLE);
  // Decoded from state so the strobe can never outlive WRITE; reset kills it at once.
  assign o_mem_write_enable = (r_state == ST_WRITE) && !i_rst;
  assign o_mem_address      = r_mem_address;
  assign o_mem_write_data   = r_mem_wdata;
  assign o_resp_valid       = r_resp_valid;
  assign o_resp_err         = r_resp_err;
  assign o_resp_rdata       = r_resp_rdata;

  // Request error classification: alignment, encoding legality and address range.
  always_comb begin
    w_misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    if (i_req_write) begin
`ifdef LSU_RMW_EN
      w_illegal = (i_req_funct3 >= 3'd3);
`else
      // Without the RMW path only full-word stores can be performed.
      w_illegal = (i_req_funct3 != 3'd2);
`endif
    end else begin
      w_illegal = (i_req_funct3 == 3'd3) || (i_req_funct3 == 3'd6) ||
                  (i_req_funct3 == 3'd7);
    end
    w_range_err = (i_req_addr >= 32'(ADDR_LIMIT));
    w_req_err   = w_misaligned || w_illegal || w_range_err;
  end

  // Load lane selection and extension using the latched offset and funct3.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = i_mem_read_data[7:0];
      2'd1:    w_byte = i_mem_read_data[15:8];
      2'd2:    w_byte = i_mem_read_data[23:16];
      2'd3:    w_byte = i_mem_read_data[31:24];
      default: w_byte = 8'd0;
    endcase
    w_half = r_off[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd2:    w_load_data = i_mem_read_data;
      3'd4:    w_load_data = {24'd0, w_byte};
      3'd5:    w_load_data = {16'd0, w_half};
      default: w_load_data = 32'd0;
    endcase
  end

`ifdef LSU_RMW_EN
  // Sub-word merge: only the addressed lane is replaced, the rest of the word is kept.
  always_comb begin
    w_merge = i_mem_read_data;
    if (r_funct3[0] == 1'b0) begin
      case (r_off)
        2'd0:    w_merge[7:0]   = r_mem_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_mem_wdata[7:0];
        2'd2:    w_merge[23:16] = r_mem_wdata[7:0];
        2'd3:    w_merge[31:24] = r_mem_wdata[7:0];
        default: w_merge        = i_mem_read_data;
      endcase
    end else begin
      if (r_off[1]) begin
        w_merge[31:16] = r_mem_wdata[15:0];
      end else begin
        w_merge[15:0]  = r_mem_wdata[15:0];
      end
    end
  end
`endif

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_mem_wdata_nxt = i_req_wdata;
          if (w_req_err) begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else if (!i_req_write) begin
            w_state_nxt = ST_LOAD;
          end
`ifdef LSU_RMW_EN
          else if (i_req_funct3 != 3'd2) begin
            w_state_nxt = ST_RMW_RD;
          end
`endif
          else begin
            w_state_nxt = ST_WRITE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_state_nxt      = ST_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = w_load_data;
      end
`ifdef LSU_RMW_EN
      ST_RMW_RD: begin
        w_state_nxt     = ST_WRITE;
        w_mem_wdata_nxt = w_merge;
      end
`endif
      ST_WRITE: begin
        w_state_nxt      = ST_RESP;
        w_resp_valid_nxt = 1'b1;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, request latches and registered response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_funct3      <= 3'd0;
      r_off         <= 2'd0;
      r_mem_address <= 32'd0;
      r_mem_wdata   <= 32'd0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      if (w_accept) begin
        r_funct3      <= i_req_funct3;
        r_off         <= i_req_addr[1:0];
        r_mem_address <= {i_req_addr[31:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic        o_resp_err;
  logic [31:0] o_resp_rdata;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic        o_mem_write_enable;
  logic [31:0] i_mem_read_data;

  lsu_mem_master #(.ADDR_LIMIT(1024)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_write        (i_req_write),
    .i_req_funct3       (i_req_funct3),
    .i_req_addr         (i_req_addr),
    .i_req_wdata        (i_req_wdata),
    .o_resp_valid       (o_resp_valid),
    .o_resp_err         (o_resp_err),
    .o_resp_rdata       (o_resp_rdata),
    .o_mem_address      (o_mem_address),
    .o_mem_write_data   (o_mem_write_data),
    .o_mem_write_enable (o_mem_write_enable),
    .i_mem_read_data    (i_mem_read_data)
  );

  always #5 i_clk = ~i_clk;

  // Word memory: combinational read, write on rising edge.
  logic [31:0] mem [0:255];
  assign i_mem_read_data = mem[o_mem_address[9:2]];
  always @(posedge i_clk) begin
    if (o_mem_write_enable) mem[o_mem_address[9:2]] <= o_mem_write_data;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  resp_t mon_r;
  wr_t   mon_w;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compare every response and every write strobe against the scoreboard.
  always @(negedge i_clk) begin
    if (o_resp_valid) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", 32'(o_resp_valid), 32'd0);
      end else begin
        mon_r = resp_q.pop_front();
        check("resp_err",   32'(o_resp_err), 32'(mon_r.err));
        check("resp_rdata", o_resp_rdata, mon_r.rdata);
        check("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
    if (o_mem_write_enable) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'(o_mem_write_enable), 32'd0);
      end else begin
        mon_w = wr_q.pop_front();
        check("wr_addr",  o_mem_address, mon_w.addr);
        check("wr_data",  o_mem_write_data, mon_w.data);
        check("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
      end
    end
  end

  task automatic wait_ready();
    @(negedge i_clk);
    for (int i = 0; i < 20 && !o_req_ready; i++) @(negedge i_clk);
    if (!o_req_ready) check("req_ready_timeout", 32'(o_req_ready), 32'd1);
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    i_req_valid  = 1'b1;
    i_req_write  = wr;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
  endtask

  task automatic junk_inputs();
    i_req_valid  = 1'b0;
    i_req_write  = 1'b1;
    i_req_funct3 = 3'd2;
    i_req_addr   = 32'h0000_0080;
    i_req_wdata  = 32'hDEAD_BEEF;
  endtask

  // Issue one request and push its expected response (and write) into the scoreboard.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata, input int lat,
                       input logic exp_we, input logic [31:0] exp_wdata, input int wlat);
    int n;
    wait_ready();
    drive(wr, f3, addr, wdata);
    n = cyc;
    resp_q.push_back('{err: exp_err, rdata: exp_rdata, cyc: n + lat});
    if (exp_we) wr_q.push_back('{addr: {addr[31:2], 2'b00}, data: exp_wdata, cyc: n + wlat});
    @(negedge i_clk);
    junk_inputs();
    for (int i = 0; i < 10 && resp_q.size() != 0; i++) @(negedge i_clk);
    check("resp_drain", 32'(resp_q.size()), 32'd0);
  endtask

  // Issue a request and pulse reset during its first post-accept cycle.
  task automatic abort(input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    wait_ready();
    drive(wr, f3, addr, wdata);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    check("we_in_reset", 32'(o_mem_write_enable), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    junk_inputs();
    @(negedge i_clk);
    check("abort_ready",      32'(o_req_ready), 32'd1);
    check("abort_resp_valid", 32'(o_resp_valid), 32'd0);
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[32'h80 >> 2] = 32'hAB0B_AB0B;
    mem[32'h78 >> 2] = 32'hFFFF_FFFF;
    i_rst = 1'b1;
    i_req_valid  = 1'b0;
    i_req_write  = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'd0;
    i_req_wdata  = 32'd0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_ready",      32'(o_req_ready), 32'd1);
    check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_resp_err",   32'(o_resp_err), 32'd0);
    check("rst_resp_rdata", o_resp_rdata, 32'd0);
    check("rst_mem_addr",   o_mem_address, 32'd0);
    check("rst_mem_wdata",  o_mem_write_data, 32'd0);
    check("rst_mem_we",     32'(o_mem_write_enable), 32'd0);

    // Loads: wr, f3, addr, wdata, err, rdata, lat, we, wdata, wlat
    issue(1'b0, 3'd2, 32'h80, 32'd0, 1'b0, 32'hAB0B_AB0B, 2, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd0, 32'h81, 32'd0, 1'b0, 32'hFFFF_FFAB, 2, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd4, 32'h81, 32'd0, 1'b0, 32'h0000_00AB, 2, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd1, 32'h82, 32'd0, 1'b0, 32'hFFFF_AB0B, 2, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd5, 32'h82, 32'd0, 1'b0, 32'h0000_AB0B, 2, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd4, 32'h80, 32'd0, 1'b0, 32'h0000_000B, 2, 1'b0, 32'd0, 0);
    // Errors: misaligned, out of range, illegal funct3
    issue(1'b0, 3'd2, 32'h7A,  32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0, 0);
    issue(1'b1, 3'd1, 32'h79,  32'h0000_BEEF, 1'b1, 32'd0, 1, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd2, 32'h400, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd3, 32'h80,  32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0, 0);
    issue(1'b1, 3'd3, 32'h80,  32'h1111_2222, 1'b1, 32'd0, 1, 1'b0, 32'd0, 0);
    // Full-word store then read back
    issue(1'b1, 3'd2, 32'h84, 32'hCAFE_F00D, 1'b0, 32'd0, 2, 1'b1, 32'hCAFE_F00D, 1);
    issue(1'b0, 3'd2, 32'h84, 32'd0, 1'b0, 32'hCAFE_F00D, 2, 1'b0, 32'd0, 0);
`ifdef LSU_RMW_EN
    issue(1'b1, 3'd0, 32'h78, 32'h1234_5655, 1'b0, 32'd0, 3, 1'b1, 32'hFFFF_FF55, 2);
    issue(1'b1, 3'd1, 32'h7A, 32'h0000_BEEF, 1'b0, 32'd0, 3, 1'b1, 32'hBEEF_FF55, 2);
    issue(1'b0, 3'd2, 32'h78, 32'd0, 1'b0, 32'hBEEF_FF55, 2, 1'b0, 32'd0, 0);
    abort(1'b1, 3'd0, 32'h78, 32'h0000_0000);
    check("mem_78", mem[32'h78 >> 2], 32'hBEEF_FF55);
`else
    issue(1'b1, 3'd0, 32'h78, 32'h1234_5655, 1'b1, 32'd0, 1, 1'b0, 32'd0, 0);
    issue(1'b0, 3'd2, 32'h78, 32'd0, 1'b0, 32'hFFFF_FFFF, 2, 1'b0, 32'd0, 0);
    check("mem_78", mem[32'h78 >> 2], 32'hFFFF_FFFF);
`endif
    abort(1'b1, 3'd2, 32'h84, 32'h1111_1111);
    check("mem_84", mem[32'h84 >> 2], 32'hCAFE_F00D);
    issue(1'b0, 3'd2, 32'h84, 32'd0, 1'b0, 32'hCAFE_F00D, 2, 1'b0, 32'd0, 0);
    check("mem_80", mem[32'h80 >> 2], 32'hAB0B_AB0B);
    repeat (3) @(negedge i_clk);
    check("resp_q_empty", 32'(resp_q.size()), 32'd0);
    check("wr_q_empty",   32'(wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
